// File: rtl/icache_read_responder_pkg.sv
// Shared types and default geometry for the I-cache read responder.
package icache_read_responder_pkg;

  localparam int ICACHE_ADDR_WIDTH  = 32;
  localparam int ICACHE_INSN_WIDTH  = 32;
  localparam int ICACHE_FETCH_WIDTH = 4;
  localparam int ICACHE_LINE_BYTES  = 16;
  localparam int ICACHE_NUM_SETS    = 64;

  localparam int ICACHE_OFFSET_BIT_WIDTH = $clog2(ICACHE_LINE_BYTES);
  localparam int ICACHE_INDEX_BIT_WIDTH  = $clog2(ICACHE_NUM_SETS);
  localparam int ICACHE_TAG_BIT_WIDTH    =
    ICACHE_ADDR_WIDTH - ICACHE_OFFSET_BIT_WIDTH - ICACHE_INDEX_BIT_WIDTH;
  localparam int ICACHE_LINE_WORD_NUM    = ICACHE_LINE_BYTES * 8 / ICACHE_INSN_WIDTH;

  typedef logic [ICACHE_TAG_BIT_WIDTH-1:0]  ICacheTagPath;
  typedef logic [ICACHE_LINE_BYTES*8-1:0]   ICacheLinePath;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    REPLAY    = 2'd3
  } ICacheRespPhase;

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped tag/data/valid storage: registered read, one write port, single-cycle flush.
module icache_line_array
  import icache_read_responder_pkg::*;
#(
  parameter int NUM_SETS  = ICACHE_NUM_SETS,
  parameter int INDEX_W   = ICACHE_INDEX_BIT_WIDTH,
  parameter int TAG_W     = ICACHE_TAG_BIT_WIDTH,
  parameter int LINE_BITS = ICACHE_LINE_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 rdEn,
  input  logic [INDEX_W-1:0]   rdIndex,
  output logic                 rdValid,
  output logic [TAG_W-1:0]     rdTag,
  output logic [LINE_BITS-1:0] rdData,
  input  logic                 wrEn,
  input  logic [INDEX_W-1:0]   wrIndex,
  input  logic [TAG_W-1:0]     wrTag,
  input  logic [LINE_BITS-1:0] wrData
);

  logic [TAG_W-1:0]     tagMem  [NUM_SETS];
  logic [LINE_BITS-1:0] dataMem [NUM_SETS];
  logic [NUM_SETS-1:0]  validBits;

  // Valid bits: flush clears all, a same-cycle refill still marks its own set valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits <= '0;
    end else begin
      if (flush) begin
        validBits <= '0;
      end
      if (wrEn) begin
        validBits[wrIndex] <= 1'b1;
      end
    end
  end

  // Tag and data storage write port
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIndex]  <= wrTag;
      dataMem[wrIndex] <= wrData;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdValid <= 1'b0;
      rdTag   <= '0;
      rdData  <= '0;
    end else if (rdEn) begin
      rdValid <= validBits[rdIndex];
      rdTag   <= tagMem[rdIndex];
      rdData  <= dataMem[rdIndex];
    end
  end

endmodule

// File: rtl/icache_read_responder.sv
// Direct-mapped blocking I-cache read responder with single-outstanding refill.
// Optional hit/miss counters under ICACHE_READ_RESPONDER_PERF_EN.
module icache_read_responder
  import icache_read_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH,
  parameter int INSN_WIDTH  = ICACHE_INSN_WIDTH,
  parameter int FETCH_WIDTH = ICACHE_FETCH_WIDTH,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int NUM_SETS    = ICACHE_NUM_SETS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            readEn,
  input  logic [ADDR_WIDTH-1:0]           readAddr,
  input  logic                            flush,
  output logic                            respValid,
  output logic [ADDR_WIDTH-1:0]           respAddr,
  output logic [FETCH_WIDTH-1:0]          respWordValid,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] respInsn,
  output logic                            busy,
  output logic                            memReq,
  output logic [ADDR_WIDTH-1:0]           memReqAddr,
  input  logic                            memReqAck,
  input  logic                            memRespValid,
  input  logic [LINE_BYTES*8-1:0]         memRespData
`ifdef ICACHE_READ_RESPONDER_PERF_EN
  ,
  output logic [31:0]                     perfHitCount,
  output logic [31:0]                     perfMissCount
`endif
);

  localparam int OFF_W       = $clog2(LINE_BYTES);
  localparam int IDX_W       = $clog2(NUM_SETS);
  localparam int TAG_W       = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int WORD_OFF_W  = $clog2(INSN_WIDTH / 8);
  localparam int LINE_WORD_W = OFF_W - WORD_OFF_W;

  ICacheRespPhase          phase;
  logic [ADDR_WIDTH-1:0]   pendAddr;
  logic [ADDR_WIDTH-1:0]   lkAddr;
  logic [ADDR_WIDTH-1:0]   lookupAddr;
  logic                    lkValid;
  logic                    lkFlushed;
  logic                    lookupEn;
  logic                    hit;
  logic                    missNow;
  logic                    wrEn;
  logic                    rdValid;
  logic [TAG_W-1:0]        rdTag;
  logic [LINE_BITS-1:0]    rdData;
  logic [LINE_WORD_W-1:0]  wordOff;
  logic [LINE_WORD_W:0]    wordSum;

  icache_line_array #(
    .NUM_SETS  (NUM_SETS),
    .INDEX_W   (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_lineArray (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .rdEn    (lookupEn),
    .rdIndex (lookupAddr[OFF_W +: IDX_W]),
    .rdValid (rdValid),
    .rdTag   (rdTag),
    .rdData  (rdData),
    .wrEn    (wrEn),
    .wrIndex (pendAddr[OFF_W +: IDX_W]),
    .wrTag   (pendAddr[ADDR_WIDTH-1 -: TAG_W]),
    .wrData  (memRespData)
  );

  // A flush issued alongside an IDLE lookup must make that lookup miss
  assign hit       = rdValid && !lkFlushed && (rdTag == lkAddr[ADDR_WIDTH-1 -: TAG_W]);
  assign missNow   = (phase == IDLE) && lkValid && !hit;
  assign respValid = lkValid && hit;
  assign respAddr  = lkAddr;
  assign busy      = (phase != IDLE) || missNow;
  assign wrEn      = (phase == MISS_WAIT) && memRespValid;
  assign wordOff   = lkAddr[OFF_W-1:WORD_OFF_W];

  // Lookup source: new fetch address in IDLE, pending miss address on replay
  always_comb begin
    lookupAddr = readAddr;
    lookupEn   = 1'b0;
    case (phase)
      IDLE: begin
        lookupAddr = readAddr;
        lookupEn   = readEn && !missNow;
      end
      REPLAY: begin
        lookupAddr = pendAddr;
        lookupEn   = 1'b1;
      end
      default: begin
        lookupAddr = readAddr;
        lookupEn   = 1'b0;
      end
    endcase
  end

  // Lookup tracking registers aligned with the array read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lkValid   <= 1'b0;
      lkFlushed <= 1'b0;
      lkAddr    <= '0;
    end else begin
      lkValid   <= lookupEn;
      lkFlushed <= flush && (phase == IDLE);
      if (lookupEn) begin
        lkAddr <= lookupAddr;
      end
    end
  end

  // Miss handling FSM with registered memory request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= IDLE;
      pendAddr   <= '0;
      memReq     <= 1'b0;
      memReqAddr <= '0;
    end else begin
      case (phase)
        IDLE: begin
          if (missNow) begin
            pendAddr   <= lkAddr;
            memReq     <= 1'b1;
            memReqAddr <= {lkAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            phase      <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (memReqAck) begin
            memReq <= 1'b0;
            phase  <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (memRespValid) begin
            phase <= REPLAY;
          end
        end
        REPLAY: begin
          phase <= IDLE;
        end
        default: begin
          memReq <= 1'b0;
          phase  <= IDLE;
        end
      endcase
    end
  end

  // Word select within the line; words past the line end are masked and zeroed
  always_comb begin
    respWordValid = '0;
    respInsn      = '0;
    wordSum       = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wordSum = {1'b0, wordOff} + (LINE_WORD_W+1)'(i);
      if (respValid && !wordSum[LINE_WORD_W]) begin
        respWordValid[i] = 1'b1;
        respInsn[i*INSN_WIDTH +: INSN_WIDTH] =
          rdData[int'(wordSum[LINE_WORD_W-1:0])*INSN_WIDTH +: INSN_WIDTH];
      end else begin
        respWordValid[i] = 1'b0;
        respInsn[i*INSN_WIDTH +: INSN_WIDTH] = '0;
      end
    end
  end

`ifdef ICACHE_READ_RESPONDER_PERF_EN
  logic lkReplay;

  // Replay responses are not counted as hits; flush clears both counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lkReplay      <= 1'b0;
      perfHitCount  <= 32'd0;
      perfMissCount <= 32'd0;
    end else begin
      lkReplay <= (phase == REPLAY);
      if (flush) begin
        perfHitCount  <= 32'd0;
        perfMissCount <= 32'd0;
      end else begin
        if (respValid && !lkReplay) begin
          perfHitCount <= perfHitCount + 32'd1;
        end
        if (missNow) begin
          perfMissCount <= perfMissCount + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_read_responder.sv
// Scoreboard bench for icache_read_responder: expected responses queued at issue, checked on output.
module tb_icache_read_responder;

  typedef struct packed {
    logic [31:0]  addr;
    logic [3:0]   wv;
    logic [127:0] insn;
  } RespExp;

  logic         clk = 1'b0;
  logic         rst;
  logic         readEn;
  logic [31:0]  readAddr;
  logic         flush;
  logic         respValid;
  logic [31:0]  respAddr;
  logic [3:0]   respWordValid;
  logic [127:0] respInsn;
  logic         busy;
  logic         memReq;
  logic [31:0]  memReqAddr;
  logic         memReqAck;
  logic         memRespValid;
  logic [127:0] memRespData;
`ifdef ICACHE_READ_RESPONDER_PERF_EN
  logic [31:0]  perfHitCount;
  logic [31:0]  perfMissCount;
`endif

  int     checkCount = 0;
  int     errorCount = 0;
  RespExp sbQ[$];
  RespExp popped;

  icache_read_responder dut (
    .clk           (clk),
    .rst           (rst),
    .readEn        (readEn),
    .readAddr      (readAddr),
    .flush         (flush),
    .respValid     (respValid),
    .respAddr      (respAddr),
    .respWordValid (respWordValid),
    .respInsn      (respInsn),
    .busy          (busy),
    .memReq        (memReq),
    .memReqAddr    (memReqAddr),
    .memReqAck     (memReqAck),
    .memRespValid  (memRespValid),
    .memRespData   (memRespData)
`ifdef ICACHE_READ_RESPONDER_PERF_EN
    ,
    .perfHitCount  (perfHitCount),
    .perfMissCount (perfMissCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] la, input int w);
    return 32'hC0DE_0000 ^ (la + 32'(w * 4));
  endfunction

  function automatic logic [127:0] lineData(input logic [31:0] la);
    logic [127:0] d;
    d = '0;
    for (int w = 0; w < 4; w++) d[w*32 +: 32] = memWord(la, w);
    return d;
  endfunction

  function automatic RespExp expResp(input logic [31:0] addr);
    RespExp e;
    logic [31:0] la;
    int off;
    e.addr = addr;
    e.wv   = 4'b0000;
    e.insn = '0;
    la  = {addr[31:4], 4'h0};
    off = int'(addr[3:2]);
    for (int i = 0; i < 4; i++) begin
      if (off + i < 4) begin
        e.wv[i] = 1'b1;
        e.insn[i*32 +: 32] = memWord(la, off + i);
      end
    end
    return e;
  endfunction

  // Scoreboard: every response must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst === 1'b1 && respValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkValue("resp_unexpected", 128'd1, 128'd0);
      end else begin
        popped = sbQ.pop_front();
        checkValue("resp_addr", respAddr, popped.addr);
        checkValue("resp_wv", respWordValid, popped.wv);
        checkValue("resp_insn", respInsn, popped.insn);
      end
    end
  end

  // One-cycle request; leaves caller at the negedge where the lookup result is visible
  task automatic readOne(input logic [31:0] addr);
    readEn   = 1'b1;
    readAddr = addr;
    sbQ.push_back(expResp(addr));
    @(negedge clk);
    readEn = 1'b0;
  endtask

  task automatic serviceMiss(input logic [31:0] la, input bit flushInWait);
    int n = 0;
    while (memReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkValue("memreq_seen", memReq, 1'b1);
    checkValue("memreq_addr", memReqAddr, la);
    memReqAck = 1'b1;
    @(negedge clk);
    memReqAck = 1'b0;
    checkValue("memreq_drop", memReq, 1'b0);
    flush = flushInWait;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    memRespValid = 1'b1;
    memRespData  = lineData(la);
    @(negedge clk);
    memRespValid = 1'b0;
    memRespData  = '0;
  endtask

  task automatic waitResp(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (respValid !== 1'b1 && n < 20);
    readEn = 1'b0;
    checkValue(tag, respValid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; readEn = 1'b0; readAddr = '0; flush = 1'b0;
    memReqAck = 1'b0; memRespValid = 1'b0; memRespData = '0;
    #1;
    checkValue("rst_respValid", respValid, 1'b0);
    checkValue("rst_busy", busy, 1'b0);
    checkValue("rst_memReq", memReq, 1'b0);
    checkValue("rst_memReqAddr", memReqAddr, 32'd0);
    checkValue("rst_respAddr", respAddr, 32'd0);
    checkValue("rst_wv", respWordValid, 4'b0000);
    checkValue("rst_insn", respInsn, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss at 0x1000
    readOne(32'h1000);
    checkValue("t1_busy_on", busy, 1'b1);
    checkValue("t1_no_resp", respValid, 1'b0);
    serviceMiss(32'h1000, 1'b0);
    waitResp("t1_resp");
    checkValue("t1_busy_off", busy, 1'b0);

    // Back-to-back hits 0x1000, 0x1004
    readEn = 1'b1; readAddr = 32'h1000; sbQ.push_back(expResp(32'h1000));
    @(negedge clk);
    checkValue("t2_hit0", respValid, 1'b1);
    readAddr = 32'h1004; sbQ.push_back(expResp(32'h1004));
    @(negedge clk);
    readEn = 1'b0;
    checkValue("t2_hit1", respValid, 1'b1);
    checkValue("t2_busy", busy, 1'b0);
    @(negedge clk);
`ifdef ICACHE_READ_RESPONDER_PERF_EN
    checkValue("t6_miss_cnt", perfMissCount, 32'd1);
    checkValue("t6_hit_cnt", perfHitCount, 32'd2);
`endif

    // Conflict: 0x1400 evicts 0x1000; readEn held during the miss must be ignored
    readEn = 1'b1; readAddr = 32'h1400; sbQ.push_back(expResp(32'h1400));
    @(negedge clk);
    checkValue("t3_busy_on", busy, 1'b1);
    serviceMiss(32'h1400, 1'b0);
    waitResp("t3_resp");
    @(negedge clk);
    readOne(32'h1000);
    checkValue("t3_evicted_miss", busy, 1'b1);
    serviceMiss(32'h1000, 1'b0);
    waitResp("t3_refill_resp");
    @(negedge clk);

    // Line-end masking on hits
    readOne(32'h1008);
    checkValue("off2_busy", busy, 1'b0);
    readOne(32'h100C);
    checkValue("off3_busy", busy, 1'b0);
    @(negedge clk);

    // Flush with a same-cycle lookup of a cached line forces a miss
    flush = 1'b1; readEn = 1'b1; readAddr = 32'h1000; sbQ.push_back(expResp(32'h1000));
    @(negedge clk);
    flush = 1'b0; readEn = 1'b0;
    checkValue("t4_flush_miss", busy, 1'b1);
    serviceMiss(32'h1000, 1'b0);
    waitResp("t4_resp");
    @(negedge clk);

    // Flush during refill: line still installed, later read hits
    readOne(32'h2008);
    checkValue("fl_busy_on", busy, 1'b1);
    serviceMiss(32'h2000, 1'b1);
    waitResp("fl_replay");
    @(negedge clk);
    readOne(32'h2000);
    checkValue("fl_hit_after", busy, 1'b0);
    checkValue("fl_hit_nomem", memReq, 1'b0);
    @(negedge clk);

    // Reset during MISS_WAIT
    readOne(32'h3000);
    checkValue("t5_busy_on", busy, 1'b1);
    begin
      int n = 0;
      while (memReq !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    checkValue("t5_memreq", memReq, 1'b1);
    memReqAck = 1'b1;
    @(negedge clk);
    memReqAck = 1'b0;
    #2 rst = 1'b0;
    #1;
    void'(sbQ.pop_back());
    checkValue("t5_busy_rst", busy, 1'b0);
    checkValue("t5_memReq_rst", memReq, 1'b0);
    checkValue("t5_memReqAddr_rst", memReqAddr, 32'd0);
    checkValue("t5_respValid_rst", respValid, 1'b0);
    checkValue("t5_respAddr_rst", respAddr, 32'd0);
    checkValue("t5_wv_rst", respWordValid, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    memRespValid = 1'b1; memRespData = lineData(32'h3000);
    @(negedge clk);
    memRespValid = 1'b0; memRespData = '0;
    @(negedge clk);
    checkValue("t5_late_busy", busy, 1'b0);
    checkValue("t5_late_resp", respValid, 1'b0);
    checkValue("t5_late_memReq", memReq, 1'b0);
    readOne(32'h3000);
    checkValue("t5_cold_again", busy, 1'b1);
    serviceMiss(32'h3000, 1'b0);
    waitResp("t5_resp");

    repeat (3) @(negedge clk);
    checkValue("sb_drain", 128'(sbQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
